// File: rtl/div_unit_if.sv
// div_unit_if: operand/result handshake bundle between EX issue and the divider.
// Carries the pipeline flush alongside the handshakes so the stall/abort controls travel together.
interface div_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      div_op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    // Pipeline side: issues operands and consumes results.
    modport master (
        output flush, in_valid, div_op, dividend, divisor, out_ready,
        input  in_ready, out_valid, result
    );

    // Divider side.
    modport slave (
        input  flush, in_valid, div_op, dividend, divisor, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU, restoring division, one quotient bit per cycle.
// Optional feature macro DIV_EARLY_OUT_EN: when defined, ops with |dividend| < |divisor|
// skip the iteration phase and go straight to sign fix-up.
module div_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [XLEN-1:0]      r_result;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [XLEN-1:0]      r_rem;
    logic [XLEN-1:0]      r_quo;
    logic [XLEN-1:0]      r_dvs;
    logic                 r_sel_rem;
    logic                 r_neg_q;
    logic                 r_neg_r;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_accept;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_early;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_borrow;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

    // Operand decode: sign handling and special cases evaluated at accept.
    assign w_signed   = ~bus.div_op[0];
    assign w_a_neg    = w_signed & bus.dividend[XLEN-1];
    assign w_b_neg    = w_signed & bus.divisor[XLEN-1];
    assign w_a_mag    = w_a_neg ? (XLEN'(0) - bus.dividend) : bus.dividend;
    assign w_b_mag    = w_b_neg ? (XLEN'(0) - bus.divisor) : bus.divisor;
    assign w_accept   = bus.in_valid & r_in_ready & ~bus.flush;
    assign w_div_zero = (bus.divisor == '0);
    assign w_ovf      = w_signed & (bus.dividend == SMIN) & (bus.divisor == '1);
`ifdef DIV_EARLY_OUT_EN
    assign w_early    = (w_a_mag < w_b_mag);
`else
    assign w_early    = 1'b0;
`endif

    // One restoring step: shifted partial remainder is XLEN+1 bits; borrow if it is below the divisor.
    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_borrow = ~w_shift[XLEN] & (w_shift[XLEN-1:0] < r_dvs);
    assign w_diff   = w_shift[XLEN-1:0] - r_dvs;

    // Sign fix-up applied in FIX.
    assign w_q_fix = r_neg_q ? (XLEN'(0) - r_quo) : r_quo;
    assign w_r_fix = r_neg_r ? (XLEN'(0) - r_rem) : r_rem;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_sel_rem   <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_sel_rem  <= bus.div_op[1];
                        if (w_div_zero) begin
                            r_result    <= bus.div_op[1] ? bus.dividend : '1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_ovf) begin
                            r_result    <= bus.div_op[1] ? '0 : SMIN;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_dvs   <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            if (w_early) begin
                                r_quo   <= '0;
                                r_rem   <= w_a_mag;
                                r_state <= S_FIX;
                            end else begin
                                r_quo   <= w_a_mag;
                                r_rem   <= '0;
                                r_cnt   <= CNT_WIDTH'(XLEN);
                                r_state <= S_CALC;
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_rem <= w_borrow ? w_shift[XLEN-1:0] : w_diff;
                        r_quo <= {r_quo[XLEN-2:0], ~w_borrow};
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                        if (r_cnt == CNT_WIDTH'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (bus.flush) begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_result    <= r_sel_rem ? w_r_fix : w_q_fix;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.flush || bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed + randomized checks of div_unit against an arithmetic reference model.
// Honours DIV_EARLY_OUT_EN for the expected latency of small-dividend ops.
module tb_div_unit;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [31:0] last_result;

    div_unit_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32), .CNT_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint mag(input logic [1:0] op, input logic [31:0] x);
        longint s;
        if (op[0]) return longint'({32'd0, x});
        s = longint'($signed(x));
        return (s < 0) ? -s : s;
    endfunction

    // Reference result from RV32M arithmetic rules.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) return op[1] ? (a % b) : (a / b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mag(op, a) < mag(op, b)) return 2;
`endif
        return 34;
    endfunction

    // Issue one op, measure latency, optionally stall the consumer, then hand the result off.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int          k;
        logic        got;
        exp = ref_result(op, a, b);
        @(negedge clk);
        chk({tag, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.div_op   = op;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk({tag, "/in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        k   = 0;
        got = 1'b0;
        while (!got && k < 100) begin
            @(negedge clk);
            if (bus.out_valid) got = 1'b1;
            else begin
                @(posedge clk);
                k++;
            end
        end
        chk({tag, "/timeout"}, 32'(got), 32'd1);
        chk({tag, "/latency"}, 32'(k + 1), 32'(ref_latency(op, a, b)));
        chk({tag, "/result"}, bus.result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "/hold_result"}, bus.result, exp);
            chk({tag, "/hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "/hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "/valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "/in_ready_back"}, 32'(bus.in_ready), 32'd1);
        last_result = exp;
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_vec         = 0;
        n_err         = 0;
        last_result   = 32'd0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.div_op    = 2'b00;
        bus.dividend  = 32'd0;
        bus.divisor   = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset/out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset/result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 0);
        run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu_backpressure", 2'b01, 32'd1234567, 32'd89, 10);
        run_op("divu_back_to_back", 2'b01, 32'd9, 32'd3, 0);
        run_op("divu_3_10", 2'b01, 32'd3, 32'd10, 0);
        run_op("remu_3_10", 2'b11, 32'd3, 32'd10, 0);
        run_op("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 0);
        run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 0);

        // Flush mid-CALC: never completes, returns to IDLE, result untouched.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.div_op   = 2'b01;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush/in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush/out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush/result", bus.result, last_result);
        repeat (40) begin
            @(posedge clk);
            #1;
            chk("flush/no_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op("after_flush_9_3", 2'b01, 32'd9, 32'd3, 0);

        // Flush in IDLE blocks the accept of a fast-path op.
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.div_op   = 2'b01;
        bus.dividend = 32'd5;
        bus.divisor  = 32'd0;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("idle_flush/in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_flush/out_valid", 32'(bus.out_valid), 32'd0);

        // Async reset mid-CALC clears outputs immediately.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.div_op   = 2'b01;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst/in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_rst/out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst/result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_result = 32'd0;

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom;
                3: begin
                    b = 32'hFFFF_FFFF;
                    if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
                end
                4:       b = a + 32'($urandom_range(1, 7));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op("random", op, a, b, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
